prog_uart_tx: RTL and testbench

//  Byte-serial UART transmitter; the return path of the UART programming link that loads the ICCM.

---
 rtl/prog_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_prog_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_uart_tx.sv
// Byte-serial 8N1/8N2 UART transmitter with a small byte FIFO and run-time bit time.
// Define PROG_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module prog_uart_tx #(
    parameter int FifoDepth = 4,
    parameter int StopBits  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [15:0]                  clks_per_bit_i,
    input  logic                         tx_valid_i,
    input  logic [7:0]                   tx_byte_i,
    output logic                         tx_ready_o,
    output logic                         tx_o,
    output logic                         tx_busy_o,
    output logic                         tx_done_o,
    output logic [$clog2(FifoDepth):0]   fifo_level_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] FULL_LVL  = LvlW'(FifoDepth);
    localparam logic [PtrW-1:0] PTR_ONE   = PtrW'(1);
    localparam logic [LvlW-1:0] LVL_ONE   = LvlW'(1);
    localparam logic [2:0]      STOP_LAST = 3'(StopBits - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef PROG_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    state_t            state_r, state_next_s;
    logic [7:0]        mem_r [FifoDepth];
    logic [PtrW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LvlW-1:0]   level_r;
    logic              push_s, pop_s, done_s, bit_end_s;
    logic [15:0]       cpb_eff_s, baud_cnt_r, bit_time_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              par_r, tx_r, done_r, busy_r;

    assign tx_ready_o   = (level_r != FULL_LVL);
    assign push_s       = tx_valid_i && tx_ready_o;
    assign cpb_eff_s    = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
    assign bit_end_s    = (baud_cnt_r == 16'd0);
    assign tx_o         = tx_r;
    assign tx_done_o    = done_r;
    assign tx_busy_o    = busy_r;
    assign fifo_level_o = level_r;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= tx_byte_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, FIFO pop and end-of-frame decode
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (level_r != '0) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef PROG_UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef PROG_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s && (bit_idx_r == STOP_LAST)) begin
                    done_s = 1'b1;
                    // Chain straight into the next frame so there is no idle gap
                    if (level_r != '0) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, bit index and shift register; bit time is latched only when a byte is popped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_r    <= 8'h00;
            bit_time_r <= 16'd1;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            par_r      <= 1'b0;
        end else if (pop_s) begin
            shift_r    <= mem_r[rd_ptr_r];
            par_r      <= even_parity(mem_r[rd_ptr_r]);
            bit_time_r <= cpb_eff_s;
            baud_cnt_r <= cpb_eff_s - 16'd1;
            bit_idx_r  <= 3'd0;
        end else if ((state_r != ST_IDLE) && bit_end_s) begin
            baud_cnt_r <= bit_time_r - 16'd1;
            if (state_r == ST_DATA) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end else if (state_r == ST_STOP) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= 3'd0;
            end
        end else if (state_r != ST_IDLE) begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
        end else begin
            baud_cnt_r <= baud_cnt_r;
        end
    end

    // Registered line, done pulse and busy flag (all one cycle behind the FSM state)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_r   <= 1'b1;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   tx_r <= 1'b1;
                ST_START:  tx_r <= 1'b0;
                ST_DATA:   tx_r <= shift_r[0];
`ifdef PROG_UART_TX_PARITY_EN
                ST_PARITY: tx_r <= par_r;
`endif
                ST_STOP:   tx_r <= 1'b1;
                default:   tx_r <= 1'b1;
            endcase
            done_r <= done_s;
            busy_r <= (state_r != ST_IDLE) || (level_r != '0);
        end
    end

endmodule

// File: tb/tb_prog_uart_tx.sv
// Directed bench for prog_uart_tx: a scoreboard of pushed bytes is checked against
// the serial line frame by frame, plus latency, flow-control, bit-time and reset checks.
module tb_prog_uart_tx;

`ifdef PROG_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STOPB = 1;
    localparam int NBITS = 10 + PAR + STOPB - 1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] clks_per_bit_i = 16'd87;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_byte_i = 8'h00;
    logic        tx_ready_o, tx_o, tx_busy_o, tx_done_o;
    logic [2:0]  fifo_level_o;

    int vec = 0;
    int errs = 0;
    int frames_seen = 0;
    logic [7:0] sb_q[$];

    prog_uart_tx dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clks_per_bit_i (clks_per_bit_i),
        .tx_valid_i     (tx_valid_i),
        .tx_byte_i      (tx_byte_i),
        .tx_ready_o     (tx_ready_o),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .tx_done_o      (tx_done_o),
        .fifo_level_o   (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk_i);
        tx_valid_i = 1'b1;
        tx_byte_i  = b;
        while (tx_ready_o !== 1'b1 && w < 20000) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 20000) check("push_ready_timeout", 32'(w), 32'(0));
        sb_q.push_back(b);
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((tx_busy_o !== 1'b0 || sb_q.size() != 0) && w < 20000) begin
            @(negedge clk_i);
            w++;
        end
        check("drain_timeout", 32'(w < 20000), 32'(1));
    endtask

    // Frame monitor: pops the expected byte at each start bit and checks every line cycle
    initial begin : monitor
        logic [7:0]  b;
        logic [15:0] bits;
        int          bt, c;
        logic        line_ok, done_ok, aborted;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && tx_o === 1'b0) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
                b = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
                bt = (clks_per_bit_i == 16'd0) ? 1 : int'(clks_per_bit_i);
                bits = 16'hFFFF;
                bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits[1+i] = b[i];
                if (PAR == 1) bits[9] = ^b;
                line_ok = 1'b1;
                done_ok = 1'b1;
                aborted = 1'b0;
                c = 0;
                while (c < NBITS * bt) begin
                    if (c != 0) @(negedge clk_i);
                    if (rst_ni !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_o !== bits[c / bt]) line_ok = 1'b0;
                    if (tx_done_o !== (c == NBITS * bt - 1)) done_ok = 1'b0;
                    c++;
                end
                if (!aborted) begin
                    check($sformatf("frame_line_%02h", b), 32'(line_ok), 32'(1));
                    check($sformatf("frame_done_%02h", b), 32'(done_ok), 32'(1));
                    frames_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         w, d;
        int         t[3];
        logic       ok;
        int         fr;

        // Reset state
        #12;
        check("rst_tx", 32'(tx_o), 32'(1));
        check("rst_busy", 32'(tx_busy_o), 32'(0));
        check("rst_done", 32'(tx_done_o), 32'(0));
        check("rst_level", 32'(fifo_level_o), 32'(0));
        check("rst_ready", 32'(tx_ready_o), 32'(1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // 1: single byte, start-bit latency of two edges
        clks_per_bit_i = 16'd87;
        push(8'h55);
        @(posedge clk_i); #1;
        check("lat_edge1_high", 32'(tx_o), 32'(1));
        @(posedge clk_i); #1;
        check("lat_edge2_low", 32'(tx_o), 32'(0));
        wait_idle();

        // 2: three back-to-back frames, done pulses 870 cycles apart, busy falls after last
        push(8'hA3);
        push(8'h0F);
        push(8'hFF);
        d = 0;
        w = 0;
        while (d < 3 && w < 5000) begin
            @(negedge clk_i);
            w++;
            if (tx_done_o === 1'b1) begin
                t[d] = w;
                d++;
            end
        end
        check("b2b_done_count", 32'(d), 32'(3));
        check("b2b_gap1", 32'(t[1] - t[0]), 32'(870));
        check("b2b_gap2", 32'(t[2] - t[1]), 32'(870));
        check("b2b_busy_at_done", 32'(tx_busy_o), 32'(1));
        @(negedge clk_i);
        check("b2b_busy_after", 32'(tx_busy_o), 32'(0));
        wait_idle();

        // 3: fill FIFO behind a frame in flight, then hold valid until ready returns
        clks_per_bit_i = 16'd16;
        push(8'h11);
        repeat (2) @(negedge clk_i);
        check("fill_inflight_level", 32'(fifo_level_o), 32'(0));
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h5A);
        @(negedge clk_i);
        check("fill_level4", 32'(fifo_level_o), 32'(4));
        check("fill_ready_low", 32'(tx_ready_o), 32'(0));
        push(8'h66);
        wait_idle();

        // 4: bit-time change mid-frame takes effect next frame; 0 means 1 cycle/bit
        clks_per_bit_i = 16'd87;
        push(8'hC6);
        repeat (300) @(negedge clk_i);
        clks_per_bit_i = 16'd16;
        push(8'h39);
        wait_idle();
        clks_per_bit_i = 16'd0;
        push(8'hA5);
        wait_idle();

        // 5: reset during data bit 4 aborts the frame and drops the queue
        clks_per_bit_i = 16'd87;
        push(8'h0F);
        push(8'h12);
        repeat (475) @(negedge clk_i);
        check("pre_rst_tx_low", 32'(tx_o), 32'(0));
        check("pre_rst_level", 32'(fifo_level_o), 32'(1));
        #2 rst_ni = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_tx", 32'(tx_o), 32'(1));
        check("mid_rst_level", 32'(fifo_level_o), 32'(0));
        check("mid_rst_busy", 32'(tx_busy_o), 32'(0));
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        fr = frames_seen;
        ok = 1'b1;
        repeat (1500) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) ok = 1'b0;
        end
        check("post_rst_quiet", 32'(ok), 32'(1));
        check("post_rst_frames", 32'(frames_seen), 32'(fr));
        push(8'h3C);
        wait_idle();
        check("post_rst_new_frame", 32'(frames_seen), 32'(fr + 1));

        // 6: parity-sensitive bytes (parity bit expected only when the option is built in)
        push(8'h07);
        push(8'h03);
        wait_idle();

        repeat (5) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
